dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate L1 data cache with its controller. It sits in the MEM stage, directly downstream of the EX/MEM pipeline register, and consumes that register's address, store data and MemRead/MemWrite controls. Hits complete in the same cycle. Misses raise `cpu_stall_o`, which freezes the pipeline registers, including EX/MEM, while the line is written back and/or refilled from a 256-bit main-memory port.

---
 rtl/dcache_if.sv | 31 +++
 rtl/dcache_ctrl.sv | 128 ++++++++++++
 tb/tb_dcache_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_if.sv
`default_nettype none
// ============================================================================
// Module   : dcache_if
// Brief    : CPU-side and memory-side signal bundle of the L1 data cache.
// Revision : 1.0
// ============================================================================
interface dcache_if;
   logic         cpu_req_i;
   logic         cpu_write_i;
   logic [31:0]  cpu_addr_i;
   logic [31:0]  cpu_wdata_i;
   logic [31:0]  cpu_rdata_o;
   logic         cpu_stall_o;
   logic         mem_req_o;
   logic         mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_wdata_o;
   logic [255:0] mem_rdata_i;
   logic         mem_ack_i;

   modport slave (
      input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
      output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
      input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o
   );
endinterface
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Brief    : Direct-mapped write-back/write-allocate L1 D-cache, 32-byte lines.
// Revision : 1.0
// ============================================================================
module dcache_ctrl #(
   parameter int LINES = 16
) (
   input  wire logic clk_i,
   input  wire logic rst_i,
   dcache_if.slave   bus
);
   localparam int c_IDX_W = $clog2(LINES);
   localparam int c_TAG_W = 27 - c_IDX_W;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WRITEBACK = 2'd1,
      S_ALLOCATE  = 2'd2
   } state_t;

   state_t               r_state;
   logic [LINES-1:0]     r_valid;
   logic [LINES-1:0]     r_dirty;
   logic [c_TAG_W-1:0]   r_tag  [LINES];
   logic [255:0]         r_data [LINES];
   logic                 r_mem_req;
   logic                 r_mem_write;
   logic [31:0]          r_mem_addr;
   logic [255:0]         r_mem_wdata;

   logic [c_IDX_W-1:0]   w_idx;
   logic [c_TAG_W-1:0]   w_tag;
   logic [2:0]           w_word;
   logic [7:0]           w_bitoff;
   logic [255:0]         w_line;
   logic                 w_hit;
   logic                 w_store_hit;
   logic                 w_refill;

   assign w_idx       = bus.cpu_addr_i[5+c_IDX_W-1:5];
   assign w_tag       = bus.cpu_addr_i[31:5+c_IDX_W];
   assign w_word      = bus.cpu_addr_i[4:2];
   assign w_bitoff    = {w_word, 5'b0};
   assign w_line      = r_data[w_idx];
   assign w_hit       = (r_state == S_IDLE) && bus.cpu_req_i && r_valid[w_idx]
                        && (r_tag[w_idx] == w_tag);
   assign w_store_hit = w_hit && bus.cpu_write_i;
   assign w_refill    = (r_state == S_ALLOCATE) && bus.mem_ack_i;

   // Reset gates the stall so every output reads 0 while rst_i is high.
   assign bus.cpu_stall_o = bus.cpu_req_i && !w_hit && !rst_i;
   assign bus.cpu_rdata_o = (w_hit && !bus.cpu_write_i) ? w_line[w_bitoff +: 32] : 32'h0;
   assign bus.mem_req_o   = r_mem_req;
   assign bus.mem_write_o = r_mem_write;
   assign bus.mem_addr_o  = r_mem_addr;
   assign bus.mem_wdata_o = r_mem_wdata;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_valid     <= '0;
         r_dirty     <= '0;
         r_mem_req   <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.cpu_req_i) begin
                  if (w_hit) begin
                     if (bus.cpu_write_i) begin
                        r_dirty[w_idx] <= 1'b1;
                     end
                  end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
                     r_state     <= S_WRITEBACK;
                     r_mem_req   <= 1'b1;
                     r_mem_write <= 1'b1;
                     r_mem_addr  <= {r_tag[w_idx], w_idx, 5'b0};
                     r_mem_wdata <= w_line;
                  end else begin
                     r_state     <= S_ALLOCATE;
                     r_mem_req   <= 1'b1;
                     r_mem_write <= 1'b0;
                     r_mem_addr  <= {w_tag, w_idx, 5'b0};
                  end
               end
            end
            S_WRITEBACK: begin
               // mem_req stays high into the refill phase.
               if (bus.mem_ack_i) begin
                  r_state     <= S_ALLOCATE;
                  r_mem_write <= 1'b0;
                  r_mem_addr  <= {w_tag, w_idx, 5'b0};
                  r_mem_wdata <= '0;
               end
            end
            S_ALLOCATE: begin
               if (bus.mem_ack_i) begin
                  r_state        <= S_IDLE;
                  r_valid[w_idx] <= 1'b1;
                  r_dirty[w_idx] <= 1'b0;
                  r_mem_req      <= 1'b0;
                  r_mem_addr     <= '0;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Tag and data arrays carry no reset; valid bits guard their contents.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (w_refill) begin
            r_data[w_idx] <= bus.mem_rdata_i;
            r_tag[w_idx]  <= w_tag;
         end else if (w_store_hit) begin
            r_data[w_idx][w_bitoff +: 32] <= bus.cpu_wdata_i;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_ctrl
// Brief    : Scoreboard bench for dcache_ctrl with a latency-programmable memory.
// Revision : 1.0
// ============================================================================
module tb_dcache_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dcache_if ifc ();

   dcache_ctrl #(.LINES(16)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (ifc.slave)
   );

   typedef struct {
      bit          is_load;
      logic [31:0] rdata;
      int          stall;
   } cexp_t;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      int          widx;
      logic [31:0] wval;
   } mexp_t;

   cexp_t cq[$];
   mexp_t mq[$];
   logic [255:0] mem [logic [31:0]];
   int lat = 10;
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] def_word(input logic [31:0] a, input int w);
      return 32'hA000_0000 | (a << 4) | w;
   endfunction

   function automatic logic [255:0] line_of(input logic [31:0] a);
      logic [255:0] l;
      if (mem.exists(a)) return mem[a];
      for (int w = 0; w < 8; w++) l[32*w +: 32] = def_word(a, w);
      return l;
   endfunction

   // Memory model: acks the L-th cycle of each mem_req_o phase.
   initial begin
      int cnt;
      mexp_t m;
      logic [255:0] l;
      cnt = 0;
      ifc.mem_ack_i   = 1'b0;
      ifc.mem_rdata_i = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            cnt = 0;
            ifc.mem_ack_i = 1'b0;
         end else begin
            if (ifc.mem_ack_i) begin
               ifc.mem_ack_i = 1'b0;
               cnt = 0;
            end
            if (ifc.mem_req_o) begin
               cnt++;
               if (cnt == lat) begin
                  ifc.mem_ack_i = 1'b1;
                  if (mq.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL mem_unexpected: got write=%0b addr=%0h expected no transfer",
                              ifc.mem_write_o, ifc.mem_addr_o);
                  end else begin
                     m = mq.pop_front();
                     chk("mem_write", {255'b0, ifc.mem_write_o}, {255'b0, m.wr});
                     chk("mem_addr", {224'b0, ifc.mem_addr_o}, {224'b0, m.addr});
                     if (m.wr) begin
                        l = ifc.mem_wdata_o;
                        chk("wb_word", {224'b0, l[32*m.widx +: 32]}, {224'b0, m.wval});
                     end
                  end
                  if (ifc.mem_write_o) mem[ifc.mem_addr_o] = ifc.mem_wdata_o;
                  else ifc.mem_rdata_i = line_of(ifc.mem_addr_o);
               end
            end
         end
      end
   end

   // Completion monitor: stall run length, load data, idle memory outputs.
   initial begin
      int scount;
      cexp_t c;
      scount = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            scount = 0;
         end else if (ifc.cpu_stall_o) begin
            scount++;
         end else if (ifc.cpu_req_i) begin
            if (cq.size() == 0) begin
               checks++; errors++;
               $display("FAIL cpu_unexpected: got completion at %0h expected none", ifc.cpu_addr_i);
            end else begin
               c = cq.pop_front();
               chk("stall_cycles", 256'(scount), 256'(c.stall));
               chk(c.is_load ? "load_data" : "store_rdata_zero",
                   {224'b0, ifc.cpu_rdata_o}, {224'b0, c.rdata});
               chk("idle_mem_out", {ifc.mem_wdata_o[253:0], ifc.mem_req_o, ifc.mem_write_o}
                   | {224'b0, ifc.mem_addr_o}, 256'b0);
            end
            scount = 0;
         end else begin
            scount = 0;
         end
      end
   end

   task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input int exp_stall);
      cexp_t c;
      int n;
      c.is_load = !wr;
      c.rdata   = wr ? 32'h0 : exp_rd;
      c.stall   = exp_stall;
      @(posedge clk); #1;
      cq.push_back(c);
      ifc.cpu_req_i   = 1'b1;
      ifc.cpu_write_i = wr;
      ifc.cpu_addr_i  = a;
      ifc.cpu_wdata_i = wd;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ifc.cpu_stall_o && n < 200);
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL access_timeout: got stall after %0d cycles expected completion", n);
      end
      @(posedge clk); #1;
      ifc.cpu_req_i   = 1'b0;
      ifc.cpu_write_i = 1'b0;
   endtask

   task automatic exp_mem(input bit wr, input logic [31:0] a, input int widx, input logic [31:0] v);
      mexp_t m;
      m.wr = wr; m.addr = a; m.widx = widx; m.wval = v;
      mq.push_back(m);
   endtask

   initial begin
      logic [255:0] l;
      l = line_of(32'h40);
      l[31:0] = 32'h1111_1111;
      mem[32'h40] = l;
      ifc.cpu_req_i   = 1'b1;
      ifc.cpu_write_i = 1'b0;
      ifc.cpu_addr_i  = 32'h40;
      ifc.cpu_wdata_i = '0;

      // Reset state, with a request already presented.
      #12;
      chk("rst_stall", {255'b0, ifc.cpu_stall_o}, 256'b0);
      chk("rst_rdata", {224'b0, ifc.cpu_rdata_o}, 256'b0);
      chk("rst_mem_req", {255'b0, ifc.mem_req_o}, 256'b0);
      chk("rst_mem_addr", {224'b0, ifc.mem_addr_o}, 256'b0);
      chk("rst_mem_wdata", ifc.mem_wdata_o, 256'b0);
      ifc.cpu_req_i = 1'b0;
      @(posedge clk); #1 rst = 1'b0;

      // Cold load, store hit, load-after-store.
      lat = 10;
      exp_mem(0, 32'h40, 0, 0);
      access(0, 32'h40, 0, 32'h1111_1111, 11);
      access(1, 32'h44, 32'hDEAD_BEEF, 0, 0);
      access(0, 32'h44, 0, 32'hDEAD_BEEF, 0);

      // Dirty eviction then clean eviction of index 2.
      exp_mem(1, 32'h40, 1, 32'hDEAD_BEEF);
      exp_mem(0, 32'h240, 0, 0);
      access(0, 32'h240, 0, def_word(32'h240, 0), 21);
      exp_mem(0, 32'h440, 0, 0);
      access(0, 32'h440, 0, def_word(32'h440, 0), 11);

      // Store-miss allocate, then its eviction carries the merged word.
      exp_mem(0, 32'h80, 0, 0);
      access(1, 32'h80, 32'h1234_5678, 0, 11);
      access(0, 32'h80, 0, 32'h1234_5678, 0);
      exp_mem(1, 32'h80, 0, 32'h1234_5678);
      exp_mem(0, 32'h280, 0, 0);
      access(0, 32'h280, 0, def_word(32'h280, 0), 21);

      // Short latencies, including L=1 on clean and dirty misses.
      lat = 3;
      exp_mem(0, 32'h100, 0, 0);
      access(0, 32'h100, 0, def_word(32'h100, 0), 4);
      lat = 1;
      exp_mem(0, 32'h120, 0, 0);
      access(0, 32'h120, 0, def_word(32'h120, 0), 2);
      access(1, 32'h124, 32'hCAFE_F00D, 0, 0);
      exp_mem(1, 32'h120, 1, 32'hCAFE_F00D);
      exp_mem(0, 32'h320, 0, 0);
      access(0, 32'h320, 0, def_word(32'h320, 0), 3);
      access(0, 32'h33C, 0, def_word(32'h320, 7), 0);

      // Reset three cycles into a refill, then the same load misses again.
      lat = 10;
      @(posedge clk); #1;
      ifc.cpu_req_i  = 1'b1;
      ifc.cpu_addr_i = 32'hC0;
      repeat (4) @(posedge clk);
      #1;
      chk("pre_rst_mem_req", {255'b0, ifc.mem_req_o}, {255'b0, 1'b1});
      #2 rst = 1'b1;
      #1;
      chk("midrst_mem_req", {255'b0, ifc.mem_req_o}, 256'b0);
      chk("midrst_stall", {255'b0, ifc.cpu_stall_o}, 256'b0);
      ifc.cpu_req_i = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      exp_mem(0, 32'hC0, 0, 0);
      access(0, 32'hC0, 0, def_word(32'hC0, 0), 11);

      repeat (3) @(posedge clk);
      chk("cpu_queue_drained", 256'(cq.size()), 256'b0);
      chk("mem_queue_drained", 256'(mq.size()), 256'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
